// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b memory-path types: arbiter state encoding, line type and default timeout.
package lc3b_types;
  localparam int unsigned LC3B_LINE_WIDTH = 128;
  localparam int unsigned DEFAULT_TIMEOUT = 1023;

  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} lc3b_arb_state;
  typedef enum logic {SIDE_I, SIDE_D} lc3b_side;
endpackage

// File: rtl/pmem_arbiter_wait_counter.sv
// Saturating wait counter with synchronous clear; terminal flags the value being loaded.
module arb_wait_counter #(
  parameter int unsigned MAX = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic terminal
);
  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (en && (count != CW'(MAX))) begin
      count_nxt = count + 1'b1;
    end
  end

  // Looking at the next value lets the sticky error rise on the same edge the limit is hit.
  assign terminal = (count_nxt == CW'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end
endmodule

// File: rtl/pmem_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one physical-memory port,
// alternating grants under contention and flagging memory that never responds.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = LC3B_LINE_WIDTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  timeout_err
);
  lc3b_arb_state         state, state_nxt;
  lc3b_side              last_grant, last_grant_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_nxt;
  logic                  is_write_q, is_write_nxt;
  logic                  is_d_q, is_d_nxt;
  logic                  i_req, d_req;
  logic                  grant, grant_d;
  logic                  serving;
  logic                  wait_terminal;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign serving = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    is_write_nxt   = is_write_q;
    is_d_nxt       = is_d_q;
    grant          = 1'b0;
    grant_d        = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant          = 1'b1;
          // On a tie the side that did not win last time goes next.
          grant_d        = d_req && (!i_req || (last_grant == SIDE_I));
          state_nxt      = grant_d ? SERVE_D : SERVE_I;
          last_grant_nxt = grant_d ? SIDE_D : SIDE_I;
          is_d_nxt       = grant_d;
          addr_nxt       = grant_d ? d_address : i_address;
          wdata_nxt      = grant_d ? d_wdata : '0;
          is_write_nxt   = grant_d && d_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= SIDE_I;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      is_d_q      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      is_write_q <= is_write_nxt;
      is_d_q     <= is_d_nxt;
      if (serving && wait_terminal) begin
        timeout_err <= 1'b1;
      end
    end
  end

  arb_wait_counter #(
    .MAX(TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant),
    .en      (serving && !pmem_resp),
    .terminal(wait_terminal)
  );

  assign pmem_read    = serving && !is_write_q;
  assign pmem_write   = serving && is_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_resp  = serving && !is_d_q && pmem_resp;
  assign d_resp  = serving && is_d_q && pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = d_resp ? pmem_rdata : '0;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: transaction-level model, responding memory, directed vectors.
module tb_pmem_arbiter;
  import lc3b_types::*;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write, timeout_err;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  pmem_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .timeout_err (timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Memory: answers on the mem_lat-th strobed cycle (never when mem_lat is 0).
  int       mem_lat = 4;
  int       scnt = 0;
  logic     force_resp = 1'b0;
  lc3b_line mem_data = '0;
  assign pmem_rdata = mem_data;

  always @(negedge clk) begin
    #1;
    if (!rst_n || !(pmem_read || pmem_write)) begin
      scnt = 0;
      pmem_resp = force_resp;
    end else begin
      scnt++;
      pmem_resp = (mem_lat != 0) && (scnt == mem_lat);
    end
  end

  // Transaction-level model: one transaction in flight, recorded as a plain record.
  logic          m_serv = 1'b0, m_d = 1'b0, m_wr = 1'b0, m_last_d = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  int            m_wait = 0;
  logic          m_order[$];

  function automatic logic pick_d(input logic ir, input logic dr, input logic last_d);
    return dr && (!ir || !last_d);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_serv <= 1'b0; m_d <= 1'b0; m_wr <= 1'b0; m_last_d <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_wait <= 0;
    end else if (!m_serv) begin
      if (i_read || d_read || d_write) begin
        m_serv   <= 1'b1;
        m_d      <= pick_d(i_read, d_read | d_write, m_last_d);
        m_last_d <= pick_d(i_read, d_read | d_write, m_last_d);
        m_addr   <= pick_d(i_read, d_read | d_write, m_last_d) ? d_address : i_address;
        m_wdata  <= pick_d(i_read, d_read | d_write, m_last_d) ? d_wdata : '0;
        m_wr     <= pick_d(i_read, d_read | d_write, m_last_d) && d_write;
        m_wait   <= 0;
        m_order.push_back(pick_d(i_read, d_read | d_write, m_last_d));
      end
    end else if (pmem_resp) begin
      m_serv <= 1'b0;
    end else if (m_wait < int'(TO)) begin
      m_wait <= m_wait + 1;
      if (m_wait + 1 == int'(TO)) m_err <= 1'b1;
    end
  end

  // Every-cycle compare against the model; also logs the observed grant order.
  logic dut_order[$];
  always @(negedge clk) begin
    #2;
    chk("pmem_read", LW'(pmem_read), LW'(m_serv && !m_wr));
    chk("pmem_write", LW'(pmem_write), LW'(m_serv && m_wr));
    chk("pmem_address", LW'(pmem_address), LW'(m_addr));
    chk("pmem_wdata", pmem_wdata, m_wdata);
    chk("i_resp", LW'(i_resp), LW'(m_serv && !m_d && pmem_resp));
    chk("d_resp", LW'(d_resp), LW'(m_serv && m_d && pmem_resp));
    chk("i_rdata", i_rdata, (m_serv && !m_d && pmem_resp) ? pmem_rdata : '0);
    chk("d_rdata", d_rdata, (m_serv && m_d && pmem_resp) ? pmem_rdata : '0);
    chk("timeout_err", LW'(timeout_err), LW'(m_err));
    if (d_resp) dut_order.push_back(1'b1);
    if (i_resp) dut_order.push_back(1'b0);
  end

  task automatic wait_resp(input logic side_d, input string tag);
    int n = 0;
    while (!(side_d ? d_resp : i_resp) && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    chk({tag, "_resp_seen"}, LW'(side_d ? d_resp : i_resp), LW'(1'b1));
  endtask

  logic exp_ord [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_pmem_address", LW'(pmem_address), '0);
    chk("rst_timeout_err", LW'(timeout_err), '0);
    rst_n = 1'b1;

    // Lone I read, memory answers on the 4th serve cycle.
    @(negedge clk);
    mem_lat = 4; mem_data = {16{8'hA5}}; i_address = 16'h1230; i_read = 1'b1;
    @(negedge clk); #2;
    chk("i_first_strobe", LW'(pmem_read), LW'(1'b1));
    chk("i_first_addr", LW'(pmem_address), LW'(16'h1230));
    wait_resp(1'b0, "i_read");
    chk("i_rdata_lit", i_rdata, {16{8'hA5}});
    chk("i_no_d_resp", LW'(d_resp), '0);
    @(negedge clk); i_read = 1'b0; #2;
    chk("i_turnaround", LW'(pmem_read), '0);

    // Lone D write, address changed mid-transaction.
    @(negedge clk);
    mem_lat = 3; d_write = 1'b1; d_address = 16'h4440; d_wdata = {8{16'hDEAD}};
    @(negedge clk); #2;
    chk("d_write_strobe", LW'(pmem_write), LW'(1'b1));
    chk("d_no_read", LW'(pmem_read), '0);
    chk("d_wdata_lit", pmem_wdata, {8{16'hDEAD}});
    d_address = 16'h0000;
    @(negedge clk); #2;
    chk("d_addr_hold", LW'(pmem_address), LW'(16'h4440));
    wait_resp(1'b1, "d_write");
    chk("d_addr_at_resp", LW'(pmem_address), LW'(16'h4440));
    @(negedge clk); d_write = 1'b0; #2;
    chk("d_idle_after", LW'(pmem_write), '0);

    // Memory response while idle is ignored.
    @(negedge clk); force_resp = 1'b1; #2;
    chk("idle_resp_i", LW'(i_resp), '0);
    chk("idle_resp_d", LW'(d_resp), '0);
    @(negedge clk); force_resp = 1'b0;

    // Fresh reset, then continuous contention: first tie goes to D, then alternate.
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    dut_order.delete(); m_order.delete();
    mem_lat = 2; mem_data = {4{32'h0BADF00D}};
    i_address = 16'h2000; d_address = 16'h3000; i_read = 1'b1; d_read = 1'b1;
    for (int n = 0; n < 100 && dut_order.size() < 6; n++) begin
      @(negedge clk); #3;
    end
    i_read = 1'b0; d_read = 1'b0;
    chk("order_len", LW'(dut_order.size()), LW'(6));
    for (int k = 0; k < 6 && k < dut_order.size(); k++) begin
      chk($sformatf("dut_order_%0d", k), LW'(dut_order[k]), LW'(exp_ord[k]));
    end
    for (int k = 0; k < 6 && k < m_order.size(); k++) begin
      chk($sformatf("model_order_%0d", k), LW'(m_order[k]), LW'(exp_ord[k]));
    end

    // Memory never answers: sticky timeout after TO serve cycles, then async reset.
    @(negedge clk);
    mem_lat = 0; i_address = 16'h5550; i_read = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #3;
      if (k == 8) chk("timeout_before", LW'(timeout_err), '0);
      if (k == 9) chk("timeout_rise", LW'(timeout_err), LW'(1'b1));
      if (k == 12) chk("timeout_hold", LW'(timeout_err), LW'(1'b1));
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_read", LW'(pmem_read), '0);
    chk("async_rst_err", LW'(timeout_err), '0);
    chk("async_rst_resp", LW'(i_resp), '0);
    chk("async_rst_addr", LW'(pmem_address), '0);
    i_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
